id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register that sits directly upstream of the 32-bit ALU.
- Captures decoded operands and control from ID, resolves data forwarding from EX/MEM and MEM/WB, and drives Operand1/Operand2/ALUControl/shiftAmount into the ALU.
- Detects load-use hazards and inserts bubbles itself; also honours a downstream stall and a branch flush.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register specifier width.
- CTRL_WIDTH, 4, ALUControl width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  downstream hold; register keeps contents.
- Flush  in  1  branch/jump squash; next state is a bubble.
- ValidIn  in  1  ID slot holds a real instruction.
- ReadData1, ReadData2  in  DATA_WIDTH  register file outputs.
- SignExtImm  in  DATA_WIDTH  sign-extended immediate.
- RsIn, RtIn, RdIn  in  REG_ADDR_WIDTH  source/destination specifiers.
- ShamtIn  in  5  shift amount field.
- ALUControlIn  in  CTRL_WIDTH  ALU opcode.
- ALUSrcIn, RegDstIn, RegWriteIn, MemReadIn, MemWriteIn, MemToRegIn  in  1 each  decoded control.
- EXMEMRegWrite  in  1;  EXMEMRd  in  REG_ADDR_WIDTH;  EXMEMResult  in  DATA_WIDTH  forwarding source 1.
- MEMWBRegWrite  in  1;  MEMWBRd  in  REG_ADDR_WIDTH;  MEMWBResult  in  DATA_WIDTH  forwarding source 2.
- Operand1, Operand2  out  DATA_WIDTH  ALU operands.
- ALUControl  out  CTRL_WIDTH;  shiftAmount  out  5  to the ALU.
- StoreData  out  DATA_WIDTH  forwarded Rt value for sw.
- WriteReg  out  REG_ADDR_WIDTH  RegDst ? Rd : Rt (registered).
- RegWriteOut, MemReadOut, MemWriteOut, MemToRegOut, ValidOut  out  1 each.
- LoadUseHazard  out  1  to IF/ID: hold PC and IF/ID this cycle.

Behaviour:
- Reset (reset=0, asynchronous): every register clears to 0, so all outputs are 0 and ValidOut=0. A release mid-cycle takes effect at the next rising edge.
- Hazard detection (combinational): LoadUseHazard = ValidOut & MemReadOut & ValidIn & (RtReg!=0) & (RtReg==RsIn | RtReg==RtIn), where RtReg is the registered Rt.
- Next-state priority per rising edge:
  - Flush: load bubble (all control 0, ValidOut=0, data fields 0).
  - else Stall: hold all registers.
  - else LoadUseHazard: load bubble.
  - else ValidIn: capture all ID inputs.
  - else (ValidIn=0): load bubble.
- Flush and Stall together: Flush wins.
- Stall masks the hazard bubble. LoadUseHazard stays asserted while stalled.
- Forwarding (combinational on the registered Rs/Rt), computed separately for A (Rs) and B (Rt):
  - EX/MEM is used when EXMEMRegWrite & EXMEMRd!=0 & EXMEMRd==src.
  - else MEM/WB is used when MEMWBRegWrite & MEMWBRd!=0 & MEMWBRd==src.
  - else the registered ReadData value is used.
  - Register 0 is never forwarded.
- Operand mapping:
  - Operand1 = forwarded A.
  - Operand2 = ALUSrc ? registered SignExtImm : forwarded B.
  - StoreData = forwarded B.
- Latency: 1 cycle from ID capture to ALU inputs. Forwarding adds no cycles.
- Bubbles carry RegWriteOut=MemWriteOut=MemReadOut=0, so they have no architectural effect.
- Arithmetic: none. Forwarding is pure muxing at full DATA_WIDTH with no truncation.

Optional Feature:
- Macro: IDEX_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs BubbleCount and FlushCount (32 bits each), both reset to 0.
  - BubbleCount increments on every edge that loads a bubble because of LoadUseHazard.
  - FlushCount increments on every edge where Flush=1.
  - Both counters saturate at 0xFFFFFFFF and do not increment while Stall=1 (except FlushCount, since Flush overrides Stall).
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=0 mid-operation with ValidOut=1 -> ValidOut, Operand1, RegWriteOut read 0 immediately, with no clock needed.
- Plain capture: ReadData1=5, ReadData2=7, ALUSrc=0, ALUControlIn=0000, ValidIn=1 -> next cycle Operand1=5, Operand2=7, ALUControl=0000.
- Forwarding priority: registered Rs=8; EXMEMRd=8 (RegWrite=1, Result=0x11) and MEMWBRd=8 (RegWrite=1, Result=0x22) -> Operand1=0x11. Then EXMEMRegWrite=0 -> Operand1=0x22. Then Rd=0 on both -> ReadData1 value.
- Load-use: lw writes $t0 (Rt=8) in EX; ID presents RsIn=8 -> LoadUseHazard=1 that cycle, next cycle ValidOut=0 and RegWriteOut=0, then the add is captured one cycle later.
- Stall vs Flush: Stall=1 holds Operand1=0x1234 for 3 cycles. Stall=1 and Flush=1 together -> bubble (ValidOut=0) on the next edge.
- IDEX_PERF_COUNTERS_EN: 2 load-use bubbles plus 1 flush -> BubbleCount=2, FlushCount=1. Preload 0xFFFFFFFF, then one more flush -> FlushCount stays 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands, resolves EX/MEM and MEM/WB
// forwarding, inserts load-use bubbles. Optional IDEX_PERF_COUNTERS_EN adds bubble/flush counters.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      ValidIn,
  input  logic [DATA_WIDTH-1:0]     ReadData1,
  input  logic [DATA_WIDTH-1:0]     ReadData2,
  input  logic [DATA_WIDTH-1:0]     SignExtImm,
  input  logic [REG_ADDR_WIDTH-1:0] RsIn,
  input  logic [REG_ADDR_WIDTH-1:0] RtIn,
  input  logic [REG_ADDR_WIDTH-1:0] RdIn,
  input  logic [4:0]                ShamtIn,
  input  logic [CTRL_WIDTH-1:0]     ALUControlIn,
  input  logic                      ALUSrcIn,
  input  logic                      RegDstIn,
  input  logic                      RegWriteIn,
  input  logic                      MemReadIn,
  input  logic                      MemWriteIn,
  input  logic                      MemToRegIn,
  input  logic                      EXMEMRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] EXMEMRd,
  input  logic [DATA_WIDTH-1:0]     EXMEMResult,
  input  logic                      MEMWBRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MEMWBRd,
  input  logic [DATA_WIDTH-1:0]     MEMWBResult,
  output logic [DATA_WIDTH-1:0]     Operand1,
  output logic [DATA_WIDTH-1:0]     Operand2,
  output logic [CTRL_WIDTH-1:0]     ALUControl,
  output logic [4:0]                shiftAmount,
  output logic [DATA_WIDTH-1:0]     StoreData,
  output logic [REG_ADDR_WIDTH-1:0] WriteReg,
  output logic                      RegWriteOut,
  output logic                      MemReadOut,
  output logic                      MemWriteOut,
  output logic                      MemToRegOut,
  output logic                      ValidOut,
  output logic                      LoadUseHazard
`ifdef IDEX_PERF_COUNTERS_EN
  ,
  output logic [31:0]               BubbleCount,
  output logic [31:0]               FlushCount
`endif
);

  logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q;
  logic [DATA_WIDTH-1:0]     rd1_q, rd2_q, imm_q;
  logic                      alu_src_q;
  logic [DATA_WIDTH-1:0]     fwd_a, fwd_b;
  logic                      capture, load_bubble;

  // Slot handshake: ValidIn marks a real ID instruction; Stall holds this slot unchanged;
  // LoadUseHazard tells IF/ID to hold while a bubble is loaded here instead.
  assign LoadUseHazard = ValidOut & MemReadOut & ValidIn & (rt_q != '0) &
                         ((rt_q == RsIn) | (rt_q == RtIn));

  assign capture     = !Flush && !Stall && !LoadUseHazard && ValidIn;
  assign load_bubble = Flush || (!Stall && !capture);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || load_bubble) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      ALUControl  <= '0;
      shiftAmount <= '0;
      WriteReg    <= '0;
      RegWriteOut <= 1'b0;
      MemReadOut  <= 1'b0;
      MemWriteOut <= 1'b0;
      MemToRegOut <= 1'b0;
      ValidOut    <= 1'b0;
    end else if (capture) begin
      rs_q        <= RsIn;
      rt_q        <= RtIn;
      rd1_q       <= ReadData1;
      rd2_q       <= ReadData2;
      imm_q       <= SignExtImm;
      alu_src_q   <= ALUSrcIn;
      ALUControl  <= ALUControlIn;
      shiftAmount <= ShamtIn;
      WriteReg    <= RegDstIn ? RdIn : RtIn;
      RegWriteOut <= RegWriteIn;
      MemReadOut  <= MemReadIn;
      MemWriteOut <= MemWriteIn;
      MemToRegOut <= MemToRegIn;
      ValidOut    <= 1'b1;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; $zero is never forwarded.
  always_comb begin
    fwd_a = rd1_q;
    if (EXMEMRegWrite && (EXMEMRd != '0) && (EXMEMRd == rs_q))
      fwd_a = EXMEMResult;
    else if (MEMWBRegWrite && (MEMWBRd != '0) && (MEMWBRd == rs_q))
      fwd_a = MEMWBResult;
  end

  always_comb begin
    fwd_b = rd2_q;
    if (EXMEMRegWrite && (EXMEMRd != '0) && (EXMEMRd == rt_q))
      fwd_b = EXMEMResult;
    else if (MEMWBRegWrite && (MEMWBRd != '0) && (MEMWBRd == rt_q))
      fwd_b = MEMWBResult;
  end

  assign Operand1  = fwd_a;
  assign Operand2  = alu_src_q ? imm_q : fwd_b;
  assign StoreData = fwd_b;

`ifdef IDEX_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      BubbleCount <= '0;
      FlushCount  <= '0;
    end else begin
      if (!Flush && !Stall && LoadUseHazard && (BubbleCount != 32'hFFFF_FFFF))
        BubbleCount <= BubbleCount + 32'd1;
      if (Flush && (FlushCount != 32'hFFFF_FFFF))
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule
